// File: rtl/palu_pipe.sv
// palu_pipe: three-stage (ID/EX/WB) ALU pipeline with a register file.
// Results written back are forwarded to the ID stage. A one-cycle
// interlock covers a consumer that directly follows its producer.
module palu_pipe #(
    parameter int WIDTH = 8,
    parameter int RAW   = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [RAW-1:0]   src1,
    input  logic [RAW-1:0]   src2,
    input  logic [RAW-1:0]   dest,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [RAW-1:0]   res_dest,
    output logic             res_zero,
    output logic             res_carry
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ONE  = 3'd2,
        OP_AND  = 3'd3,
        OP_NAND = 3'd4,
        OP_SRL  = 3'd5,
        OP_SRA  = 3'd6,
        OP_CPA  = 3'd7
    } opcode_e;

    localparam int NREG = 2**RAW;

    // Architectural register file
    logic [WIDTH-1:0] r_regFile [NREG];

    // EX stage registers
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    opcode_e          r_opcodeEx;
    logic [RAW-1:0]   r_destEx;
    logic             r_validEx;

    // WB stage registers
    logic [WIDTH-1:0] r_aluOut;
    logic [RAW-1:0]   r_destWb;
    logic             r_carryWb;
    logic             r_validWb;

    // Combinational nets
    opcode_e          w_opcode;
    logic             w_uses1;
    logic             w_uses2;
    logic             w_hazard;
    logic             w_accept;
    logic [WIDTH-1:0] w_opnd1;
    logic [WIDTH-1:0] w_opnd2;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_aluRes;
    logic             w_aluCarry;

    assign w_opcode = opcode_e'(opcode);

    // Decode which source registers the presented instruction actually reads
    always_comb begin
        w_uses1 = 1'b0;
        w_uses2 = 1'b0;
        case (w_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_NAND: begin
                w_uses1 = 1'b1;
                w_uses2 = 1'b1;
            end
            OP_SRL, OP_SRA, OP_CPA: begin
                w_uses1 = 1'b1;
            end
            default: begin
                w_uses1 = 1'b0;
                w_uses2 = 1'b0;
            end
        endcase
    end

    // The only unresolvable hazard is a producer still in EX; WB is bypassed
    assign w_hazard = r_validEx &&
                      ((w_uses1 && (src1 == r_destEx)) ||
                       (w_uses2 && (src2 == r_destEx)));
    assign in_ready = !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Operand fetch: WB bypass wins over the register file, including on the write edge
    always_comb begin
        w_opnd1 = r_regFile[src1];
        w_opnd2 = r_regFile[src2];
        if (r_validWb && (src1 == r_destWb)) begin
            w_opnd1 = r_aluOut;
        end
        if (r_validWb && (src2 == r_destWb)) begin
            w_opnd2 = r_aluOut;
        end
    end

    assign w_sum  = {1'b0, r_op1} + {1'b0, r_op2};
    assign w_diff = {1'b0, r_op1} - {1'b0, r_op2};

    // ALU: the extra top bit of sum/diff gives carry-out and borrow respectively
    always_comb begin
        w_aluRes   = '0;
        w_aluCarry = 1'b0;
        case (r_opcodeEx)
            OP_ADD: begin
                w_aluRes   = w_sum[WIDTH-1:0];
                w_aluCarry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_aluRes   = w_diff[WIDTH-1:0];
                w_aluCarry = w_diff[WIDTH];
            end
            OP_ONE:  w_aluRes = {{(WIDTH-1){1'b0}}, 1'b1};
            OP_AND:  w_aluRes = r_op1 & r_op2;
            OP_NAND: w_aluRes = ~(r_op1 & r_op2);
            OP_SRL:  w_aluRes = {1'b0, r_op1[WIDTH-1:1]};
            OP_SRA:  w_aluRes = {r_op1[WIDTH-1], r_op1[WIDTH-1:1]};
            OP_CPA:  w_aluRes = r_op1;
            default: w_aluRes = '0;
        endcase
    end

    // ID -> EX: capture operands on a transfer, otherwise insert a bubble
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_opcodeEx <= OP_ADD;
            r_destEx   <= '0;
            r_validEx  <= 1'b0;
        end else if (w_accept) begin
            r_op1      <= w_opnd1;
            r_op2      <= w_opnd2;
            r_opcodeEx <= w_opcode;
            r_destEx   <= dest;
            r_validEx  <= 1'b1;
        end else begin
            r_validEx  <= 1'b0;
        end
    end

    // EX -> WB: result registers hold their last value across bubbles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_aluOut  <= '0;
            r_destWb  <= '0;
            r_carryWb <= 1'b0;
            r_validWb <= 1'b0;
        end else begin
            r_validWb <= r_validEx;
            if (r_validEx) begin
                r_aluOut  <= w_aluRes;
                r_destWb  <= r_destEx;
                r_carryWb <= w_aluCarry;
            end
        end
    end

    // Write-back: register 0 is an ordinary register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regFile[i] <= '0;
            end
        end else if (r_validWb) begin
            r_regFile[r_destWb] <= r_aluOut;
        end
    end

    // The zero flag is derived from the held result so it reads 1 straight out of reset
    assign res_valid = r_validWb;
    assign res_data  = r_aluOut;
    assign res_dest  = r_destWb;
    assign res_zero  = (r_aluOut == '0);
    assign res_carry = r_carryWb;

endmodule

// File: tb/tb_palu_pipe.sv
// tb_palu_pipe: directed vector table plus hand-written interlock,
// forwarding and mid-flight reset sequences for palu_pipe (WIDTH=8, RAW=3).
module tb_palu_pipe;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] ONE  = 3'd2;
    localparam logic [2:0] AND  = 3'd3;
    localparam logic [2:0] NAND = 3'd4;
    localparam logic [2:0] SRL  = 3'd5;
    localparam logic [2:0] SRA  = 3'd6;
    localparam logic [2:0] CPA  = 3'd7;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [2:0] dest;
    logic       res_valid;
    logic [7:0] res_data;
    logic [2:0] res_dest;
    logic       res_zero;
    logic       res_carry;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] op;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [2:0] d;
        logic [7:0] data;
        logic       zero;
        logic       carry;
    } vec_t;

    vec_t vecs[$];

    palu_pipe #(.WIDTH(8), .RAW(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .src1      (src1),
        .src2      (src2),
        .dest      (dest),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_dest  (res_dest),
        .res_zero  (res_zero),
        .res_carry (res_carry)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop if something wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                                input logic [2:0] d, input logic [7:0] data,
                                input logic zero, input logic carry);
        vec_t v;
        v.op = op; v.s1 = s1; v.s2 = s2; v.d = d;
        v.data = data; v.zero = zero; v.carry = carry;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an instruction and hold it until it is transferred (bounded wait)
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] s1,
                                 input logic [2:0] s2, input logic [2:0] d);
        logic acc;
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        opcode   = op;
        src1     = s1;
        src2     = s2;
        dest     = d;
        for (int k = 0; k < 8; k++) begin
            #1;
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        opcode   = 3'd0;
        src1     = 3'd0;
        src2     = 3'd0;
        dest     = 3'd0;

        // Each vector runs alone: it is presented while the previous one sits in WB,
        // so every dependent operand is taken from the bypass on the write edge.
        vecs.push_back(mk(ONE,  0, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk(ONE,  0, 0, 2, 8'h01, 0, 0));
        vecs.push_back(mk(ONE,  0, 0, 5, 8'h01, 0, 0));
        vecs.push_back(mk(ADD,  1, 2, 3, 8'h02, 0, 0));
        vecs.push_back(mk(CPA,  3, 0, 4, 8'h02, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h02, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h04, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h08, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h10, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h20, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h40, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 1, 8'h80, 0, 0));
        vecs.push_back(mk(ADD,  1, 1, 5, 8'h00, 1, 1));
        vecs.push_back(mk(ONE,  0, 0, 6, 8'h01, 0, 0));
        vecs.push_back(mk(SUB,  0, 6, 7, 8'hFF, 0, 1));
        vecs.push_back(mk(SRA,  1, 0, 2, 8'hC0, 0, 0));
        vecs.push_back(mk(SRL,  1, 0, 3, 8'h40, 0, 0));
        vecs.push_back(mk(NAND, 7, 7, 4, 8'h00, 1, 0));
        vecs.push_back(mk(AND,  2, 3, 5, 8'h40, 0, 0));
        vecs.push_back(mk(SUB,  2, 3, 6, 8'h80, 0, 0));
        vecs.push_back(mk(ADD,  2, 1, 2, 8'h40, 0, 1));
        vecs.push_back(mk(ADD,  3, 3, 0, 8'h80, 0, 0));
        vecs.push_back(mk(CPA,  0, 0, 1, 8'h80, 0, 0));
        vecs.push_back(mk(SUB,  3, 3, 4, 8'h00, 1, 0));

        // Reset state, checked while reset is held and again after release
        #7;
        checkOutput("rst res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst res_data",  {24'd0, res_data},  32'd0);
        checkOutput("rst res_zero",  {31'd0, res_zero},  32'd1);
        checkOutput("rst in_ready",  {31'd0, in_ready},  32'd1);
        #5;
        reset_n = 1'b1;
        #1;
        checkOutput("rel res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rel res_zero",  {31'd0, res_zero},  32'd1);
        checkOutput("rel res_carry", {31'd0, res_carry}, 32'd0);
        checkOutput("rel res_dest",  {29'd0, res_dest},  32'd0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d);
            in_valid = 1'b0;
            tick();
            checkOutput($sformatf("v%0d valid", i), {31'd0, res_valid}, 32'd1);
            checkOutput($sformatf("v%0d data", i),  {24'd0, res_data},  {24'd0, vecs[i].data});
            checkOutput($sformatf("v%0d dest", i),  {29'd0, res_dest},  {29'd0, vecs[i].d});
            checkOutput($sformatf("v%0d zero", i),  {31'd0, res_zero},  {31'd0, vecs[i].zero});
            checkOutput($sformatf("v%0d carry", i), {31'd0, res_carry}, {31'd0, vecs[i].carry});
        end
        tick();
        tick();

        // Interlock: ADD r2=r1+r1 right behind ONE r1 stalls exactly one cycle
        applyStimulus(ONE, 0, 0, 1);
        in_valid = 1'b1;
        opcode   = ADD;
        src1     = 3'd1;
        src2     = 3'd1;
        dest     = 3'd2;
        #1;
        checkOutput("ilk stall", {31'd0, in_ready}, 32'd0);
        tick();
        #1;
        checkOutput("ilk release",  {31'd0, in_ready},  32'd1);
        checkOutput("ilk producer", {24'd0, res_data},  32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("ilk bubble", {31'd0, res_valid}, 32'd0);
        tick();
        checkOutput("ilk valid", {31'd0, res_valid}, 32'd1);
        checkOutput("ilk data",  {24'd0, res_data},  32'd2);
        checkOutput("ilk dest",  {29'd0, res_dest},  32'd2);
        tick();

        // No false stall: ONE r1; ONE r1 (no sources); CPA r3=r2 with unused src2=r1
        applyStimulus(ONE, 0, 0, 1);
        opcode = ONE; src1 = 3'd1; src2 = 3'd1; dest = 3'd1;
        #1;
        checkOutput("nfs one", {31'd0, in_ready}, 32'd1);
        applyStimulus(ONE, 1, 1, 1);
        opcode = CPA; src1 = 3'd2; src2 = 3'd1; dest = 3'd3;
        #1;
        checkOutput("nfs cpa", {31'd0, in_ready}, 32'd1);
        applyStimulus(CPA, 2, 1, 3);
        in_valid = 1'b0;
        tick();
        checkOutput("nfs cpa data", {24'd0, res_data}, 32'd2);
        checkOutput("nfs cpa dest", {29'd0, res_dest}, 32'd3);
        tick();
        tick();

        // Distance two: ADD r5; ONE r6; ADD r7=r5+r5 back to back with no stall
        applyStimulus(ADD, 1, 1, 5);
        opcode = ONE; src1 = 3'd0; src2 = 3'd0; dest = 3'd6;
        #1;
        checkOutput("d2 ready1", {31'd0, in_ready}, 32'd1);
        applyStimulus(ONE, 0, 0, 6);
        checkOutput("d2 first data", {24'd0, res_data}, 32'd2);
        opcode = ADD; src1 = 3'd5; src2 = 3'd5; dest = 3'd7;
        #1;
        checkOutput("d2 ready2", {31'd0, in_ready}, 32'd1);
        applyStimulus(ADD, 5, 5, 7);
        in_valid = 1'b0;
        checkOutput("d2 second data", {24'd0, res_data}, 32'd1);
        tick();
        checkOutput("d2 third data", {24'd0, res_data}, 32'd4);
        checkOutput("d2 third dest", {29'd0, res_dest}, 32'd7);
        tick();
        tick();

        // Mid-flight reset: ONE r6 in WB, ADD r7 in EX, short reset pulse between edges
        applyStimulus(ONE, 0, 0, 6);
        applyStimulus(ADD, 1, 1, 7);
        in_valid = 1'b0;
        checkOutput("mfr pre valid", {31'd0, res_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mfr res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("mfr res_data",  {24'd0, res_data},  32'd0);
        checkOutput("mfr res_dest",  {29'd0, res_dest},  32'd0);
        checkOutput("mfr res_zero",  {31'd0, res_zero},  32'd1);
        checkOutput("mfr res_carry", {31'd0, res_carry}, 32'd0);
        checkOutput("mfr in_ready",  {31'd0, in_ready},  32'd1);
        #2;
        reset_n = 1'b1;
        tick();
        checkOutput("mfr post valid", {31'd0, res_valid}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(CPA, 3'(r), 3'd0, 3'(r));
            in_valid = 1'b0;
            tick();
            checkOutput($sformatf("mfr r%0d", r), {24'd0, res_data}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
